// File: rtl/axicb_mst_if.sv
// Per-master front end for the crossbar: registers AW/W/AR with ID masking,
// bounds outstanding writes/reads, and passes B/R responses straight through.
module axicb_mst_if #(
  parameter int                  AXI_ID_W        = 8,
  parameter logic [AXI_ID_W-1:0] MST_ID_MASK     = 'h00,
  parameter int                  MST_OSTDREQ_NUM = 4,
  parameter int                  AWCH_W          = 8,
  parameter int                  WCH_W           = 8,
  parameter int                  BCH_W           = 8,
  parameter int                  ARCH_W          = 8,
  parameter int                  RCH_W           = 8
) (
  input  logic              aclk,
  input  logic              arst,
  // master side
  input  logic              i_awvalid,
  output logic              i_awready,
  input  logic [AWCH_W-1:0] i_awch,
  input  logic              i_wvalid,
  output logic              i_wready,
  input  logic              i_wlast,
  input  logic [WCH_W-1:0]  i_wch,
  output logic              i_bvalid,
  input  logic              i_bready,
  output logic [BCH_W-1:0]  i_bch,
  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ARCH_W-1:0] i_arch,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic              i_rlast,
  output logic [RCH_W-1:0]  i_rch,
  // switch side
  output logic              o_awvalid,
  input  logic              o_awready,
  output logic [AWCH_W-1:0] o_awch,
  output logic              o_wvalid,
  input  logic              o_wready,
  output logic              o_wlast,
  output logic [WCH_W-1:0]  o_wch,
  input  logic              o_bvalid,
  output logic              o_bready,
  input  logic [BCH_W-1:0]  o_bch,
  output logic              o_arvalid,
  input  logic              o_arready,
  output logic [ARCH_W-1:0] o_arch,
  input  logic              o_rvalid,
  output logic              o_rready,
  input  logic              o_rlast,
  input  logic [RCH_W-1:0]  o_rch,
  // status
  output logic [7:0]        wr_ostd,
  output logic [7:0]        rd_ostd
);

  localparam logic [7:0] OSTD_MAX = 8'(MST_OSTDREQ_NUM);

  logic              aw_load, w_load, ar_load;
  logic              b_done, r_done;
  logic [AWCH_W-1:0] aw_masked;
  logic [ARCH_W-1:0] ar_masked;

  // ID mask applied on load so the registered payload is already in switch form
  always_comb begin
    aw_masked                 = i_awch;
    aw_masked[AXI_ID_W-1:0]   = i_awch[AXI_ID_W-1:0] | MST_ID_MASK;
    ar_masked                 = i_arch;
    ar_masked[AXI_ID_W-1:0]   = i_arch[AXI_ID_W-1:0] | MST_ID_MASK;
  end

  assign i_awready = (!o_awvalid || o_awready) && (wr_ostd < OSTD_MAX);
  assign i_arready = (!o_arvalid || o_arready) && (rd_ostd < OSTD_MAX);
  assign i_wready  = !o_wvalid || o_wready;

  assign aw_load = i_awvalid && i_awready;
  assign ar_load = i_arvalid && i_arready;
  assign w_load  = i_wvalid  && i_wready;

  assign b_done = o_bvalid && i_bready;
  assign r_done = o_rvalid && i_rready && o_rlast;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      o_awvalid <= 1'b0;
      o_awch    <= '0;
    end else if (aw_load) begin
      o_awvalid <= 1'b1;
      o_awch    <= aw_masked;
    end else if (o_awready) begin
      o_awvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      o_wvalid <= 1'b0;
      o_wlast  <= 1'b0;
      o_wch    <= '0;
    end else if (w_load) begin
      o_wvalid <= 1'b1;
      o_wlast  <= i_wlast;
      o_wch    <= i_wch;
    end else if (o_wready) begin
      o_wvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      o_arvalid <= 1'b0;
      o_arch    <= '0;
    end else if (ar_load) begin
      o_arvalid <= 1'b1;
      o_arch    <= ar_masked;
    end else if (o_arready) begin
      o_arvalid <= 1'b0;
    end
  end

  // Simultaneous request and completion cancel; completion at zero is dropped
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ostd <= '0;
    end else if (aw_load && !b_done) begin
      wr_ostd <= wr_ostd + 8'd1;
    end else if (b_done && !aw_load && (wr_ostd != '0)) begin
      wr_ostd <= wr_ostd - 8'd1;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rd_ostd <= '0;
    end else if (ar_load && !r_done) begin
      rd_ostd <= rd_ostd + 8'd1;
    end else if (r_done && !ar_load && (rd_ostd != '0)) begin
      rd_ostd <= rd_ostd - 8'd1;
    end
  end

  assign i_bvalid = o_bvalid;
  assign o_bready = i_bready;
  assign i_bch    = o_bch;

  assign i_rvalid = o_rvalid;
  assign o_rready = i_rready;
  assign i_rlast  = o_rlast;
  assign i_rch    = o_rch;

endmodule

// File: tb/tb_axicb_mst_if.sv
// Directed bench for axicb_mst_if: reset, ID masking, outstanding limits,
// response pass-through and W-channel backpressure.
module tb_axicb_mst_if;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        i_awvalid = 0, i_awready;
  logic [15:0] i_awch = '0;
  logic        i_wvalid = 0, i_wready, i_wlast = 0;
  logic [7:0]  i_wch = '0;
  logic        i_bvalid, i_bready = 0;
  logic [7:0]  i_bch;
  logic        i_arvalid = 0, i_arready;
  logic [15:0] i_arch = '0;
  logic        i_rvalid, i_rready = 0, i_rlast;
  logic [7:0]  i_rch;
  logic        o_awvalid, o_awready = 0;
  logic [15:0] o_awch;
  logic        o_wvalid, o_wready = 0, o_wlast;
  logic [7:0]  o_wch;
  logic        o_bvalid = 0, o_bready;
  logic [7:0]  o_bch = '0;
  logic        o_arvalid, o_arready = 0;
  logic [15:0] o_arch;
  logic        o_rvalid = 0, o_rready, o_rlast = 0;
  logic [7:0]  o_rch = '0;
  logic [7:0]  wr_ostd, rd_ostd;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axicb_mst_if #(
    .AXI_ID_W(8), .MST_ID_MASK(8'h10), .MST_OSTDREQ_NUM(4),
    .AWCH_W(16), .WCH_W(8), .BCH_W(8), .ARCH_W(16), .RCH_W(8)
  ) dut (
    .aclk(aclk), .arst(arst),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .wr_ostd(wr_ostd), .rd_ostd(rd_ostd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic        in_hs, out_hs, held;
    logic [7:0]  held_wch;
    logic        held_wlast;
    int          idx, rcv;

    // reset state
    tick(); tick();
    chk("rst_awvalid", 32'(o_awvalid), 0);
    chk("rst_wvalid",  32'(o_wvalid),  0);
    chk("rst_arvalid", 32'(o_arvalid), 0);
    chk("rst_wr_ostd", 32'(wr_ostd), 0);
    chk("rst_rd_ostd", 32'(rd_ostd), 0);
    arst = 1'b0;
    tick();
    chk("rel_awready", 32'(i_awready), 1);
    chk("rel_wready",  32'(i_wready),  1);
    chk("rel_arready", 32'(i_arready), 1);

    // ID forcing, switch side stalled
    i_awvalid = 1; i_awch = 16'hAB05;
    tick();
    i_awvalid = 0;
    chk("aw_valid", 32'(o_awvalid), 1);
    chk("aw_id",    32'(o_awch), 32'hAB15);
    chk("wr_ostd1", 32'(wr_ostd), 1);
    i_arvalid = 1; i_arch = 16'hCD1F;
    tick();
    i_arvalid = 0;
    chk("ar_id",    32'(o_arch), 32'hCD1F);
    chk("rd_ostd1", 32'(rd_ostd), 1);
    chk("aw_hold",  32'(o_awch), 32'hAB15);
    chk("aw_full_ready", 32'(i_awready), 0);

    // drain slices and retire one write and one read together
    o_awready = 1; o_arready = 1;
    o_bvalid = 1; i_bready = 1; o_rvalid = 1; o_rlast = 1; i_rready = 1;
    tick();
    o_rvalid = 0; o_rlast = 0;
    chk("drain_wr", 32'(wr_ostd), 0);
    chk("drain_rd", 32'(rd_ostd), 0);
    chk("drain_awvalid", 32'(o_awvalid), 0);
    chk("drain_arvalid", 32'(o_arvalid), 0);
    tick();
    o_bvalid = 0;
    chk("b_at_zero", 32'(wr_ostd), 0);

    // write limit: 5 back-to-back AWs, no B
    for (int k = 0; k < 5; k++) begin
      i_awvalid = 1; i_awch = 16'h3000 + 16'(k < 4 ? k : 4);
      #1;
      chk("lim_awready", 32'(i_awready), (k < 4) ? 1 : 0);
      tick();
      chk("lim_wr_ostd", 32'(wr_ostd), (k < 4) ? 32'(k + 1) : 4);
      if (k < 4) chk("lim_awch", 32'(o_awch), 32'h3010 + 32'(k));
      else       chk("lim_awvalid", 32'(o_awvalid), 0);
    end
    o_bvalid = 1;
    tick();
    o_bvalid = 0;
    chk("lim_b_wr", 32'(wr_ostd), 3);
    chk("lim_reopen", 32'(i_awready), 1);
    tick();
    i_awvalid = 0;
    chk("lim_5th_wr", 32'(wr_ostd), 4);
    chk("lim_5th_ch", 32'(o_awch), 32'h3014);

    // bring count to 2, then AW and B in the same cycle
    o_bvalid = 1;
    tick(); tick();
    chk("sim_pre", 32'(wr_ostd), 2);
    i_bready = 0; o_bch = 8'h5A;
    #1;
    chk("b_valid_pass", 32'(i_bvalid), 1);
    chk("b_ch_pass",    32'(i_bch), 32'h5A);
    chk("b_ready_pass", 32'(o_bready), 0);
    i_bready = 1; i_awvalid = 1; i_awch = 16'h4001;
    tick();
    o_bvalid = 0;
    chk("sim_wr", 32'(wr_ostd), 2);
    tick();
    i_awvalid = 0; o_awready = 0;
    chk("pre_rst_wr", 32'(wr_ostd), 3);
    chk("pre_rst_awvalid", 32'(o_awvalid), 1);

    // asynchronous reset mid-transfer
    #2 arst = 1;
    #1;
    chk("arst_awvalid", 32'(o_awvalid), 0);
    chk("arst_wr", 32'(wr_ostd), 0);
    @(posedge aclk); #1 arst = 0;
    tick();
    chk("arst_rel_awready", 32'(i_awready), 1);

    // read burst with rready toggling
    o_arready = 1; i_arvalid = 1; i_arch = 16'h7702;
    tick(); tick();
    i_arvalid = 0;
    chk("rd_two", 32'(rd_ostd), 2);
    for (int b = 0; b < 8; b++) begin
      o_rvalid = 1; o_rch = 8'h80 + 8'(b); o_rlast = (b == 7); i_rready = 1;
      #1;
      chk("r_ch",    32'(i_rch), 32'h80 + 32'(b));
      chk("r_last",  32'(i_rlast), (b == 7) ? 1 : 0);
      chk("r_valid", 32'(i_rvalid), 1);
      tick();
      chk("r_ostd_hs", 32'(rd_ostd), (b == 7) ? 1 : 2);
      i_rready = 0;
      #1;
      chk("r_ready_pass", 32'(o_rready), 0);
      tick();
      chk("r_ostd_stall", 32'(rd_ostd), (b == 7) ? 1 : 2);
    end
    o_rvalid = 0; o_rlast = 0;

    // W stream under 1,0,0 backpressure
    idx = 0; rcv = 0; held = 0; held_wch = '0; held_wlast = 0;
    for (int c = 0; c < 100 && rcv < 16; c++) begin
      o_wready = (c % 3 == 0);
      i_wvalid = (idx < 16);
      i_wch    = 8'hA0 + 8'(idx);
      i_wlast  = (idx == 15);
      #1;
      if (held) begin
        chk("w_hold_ch",   32'(o_wch), 32'(held_wch));
        chk("w_hold_last", 32'(o_wlast), 32'(held_wlast));
      end
      if (o_wready) chk("w_full_rate", 32'(i_wready), 1);
      in_hs  = i_wvalid && i_wready;
      out_hs = o_wvalid && o_wready;
      if (out_hs) begin
        chk("w_order", 32'(o_wch), 32'hA0 + 32'(rcv));
        chk("w_last",  32'(o_wlast), (rcv == 15) ? 1 : 0);
        rcv++;
      end
      held = o_wvalid && !o_wready;
      held_wch = o_wch; held_wlast = o_wlast;
      tick();
      if (in_hs) idx++;
    end
    i_wvalid = 0;
    chk("w_count", 32'(rcv), 16);
    chk("w_sent",  32'(idx), 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axicb_mst_if.md
# axicb_mst_if

Per-master front end that sits directly upstream of the master switch, one instance per master port. It registers the AW, W and AR request channels and forces the master's ID mask into every request ID. It limits write and read outstanding transactions per master and passes B and R responses back combinationally. This bounds each master's share of the switch's write-grant FIFO and of slave response bandwidth.

## Interface
- AXI_ID_W, 8, ID field width; ID occupies bits [AXI_ID_W-1:0] of every channel bus
- MST_ID_MASK, 'h00, OR-ed into the ID of every AW/AR request
- MST_OSTDREQ_NUM, 4, max outstanding writes and, separately, max outstanding reads; legal range 1..255
- AWCH_W / WCH_W / BCH_W / ARCH_W / RCH_W, 8 each, concatenated channel widths; each of AWCH_W, BCH_W, ARCH_W and RCH_W must be >= AXI_ID_W
- aclk  in  1  clock
- arst  in  1  asynchronous reset, active-high; one clock domain only
- i_awvalid/i_awready/i_awch  in/out/in  1/1/AWCH_W  write address from master
- i_wvalid/i_wready/i_wlast/i_wch  in/out/in/in  1/1/1/WCH_W  write data from master
- i_bvalid/i_bready/i_bch  out/in/out  1/1/BCH_W  write response to master
- i_arvalid/i_arready/i_arch  in/out/in  1/1/ARCH_W  read address from master
- i_rvalid/i_rready/i_rlast/i_rch  out/in/out/out  1/1/1/RCH_W  read data to master
- o_aw*, o_w*, o_b*, o_ar*, o_r*  mirror set toward the switch, same widths, opposite directions
- wr_ostd  out  8  current outstanding write count
- rd_ostd  out  8  current outstanding read count

## Operation
- **AW, AR, W slices.** Each is a one-entry register slice with a valid flag.
  - The slice loads on an input handshake.
  - It empties on an output handshake without a simultaneous load.
  - Slice ready is (!o_xvalid | o_xready).
- **ID forcing.**
  - o_awch = registered i_awch with bits [AXI_ID_W-1:0] replaced by (ID | MST_ID_MASK).
  - o_arch is formed the same way.
  - All other bits are unmodified.
- **Write outstanding limit.**
  - i_awready = slice ready & (wr_ostd < MST_OSTDREQ_NUM).
  - wr_ostd increments on the i_aw handshake.
  - wr_ostd decrements on the i_b handshake (i_bvalid & i_bready).
  - If both happen in the same cycle, wr_ostd is unchanged.
  - A decrement at 0 is ignored: saturate at 0, no wrap.
- **Read outstanding limit.** Same rules as writes, with these differences:
  - The limit uses rd_ostd.
  - rd_ostd decrements only on an i_r handshake with i_rlast=1.
- **W not gated.** W beats are not gated by wr_ostd. W may precede AW, per AXI.
- **Responses pass through unmodified.**
  - i_bvalid=o_bvalid, o_bready=i_bready, i_bch=o_bch.
  - R channel likewise, including rlast.
  - No ID restoration: the master sees the masked ID.
- **Counter width.** Counters are 8 bits wide. Comparisons are unsigned.

## Timing
- **Reset values** (arst asserted, asynchronous):
  - o_awvalid=o_wvalid=o_arvalid=0.
  - Slice payload registers 0.
  - wr_ostd=rd_ostd=0.
  - i_awready/i_wready/i_arready=1 one cycle after reset release and onward, because they are combinational from the cleared state.
  - Combinational B/R outputs follow o_b*/o_r* (and i_bready/i_rready) even during reset.
- **Request latency.** An input handshake in cycle N gives o_xvalid=1 and payload stable from cycle N+1.
- **Throughput.** One beat per cycle sustained while o_xready=1.
- **Ready path.** Input ready depends combinationally on output ready. Valid and payload are registered.
- **AXI stability.** Once o_xvalid=1, valid and payload hold until o_xready=1.
- **Response latency.** B and R are 0 cycles (combinational).
- **Counter update.** wr_ostd/rd_ostd update the cycle after the causing handshake. i_awready/i_arready drop in the cycle where the count equals the limit.
- **Reset mid-burst.** In-flight slice contents and counters are discarded. No recovery of partial bursts is required.

## Test plan
- **Reset.**
  - Stimulus: assert arst mid-transfer with o_awvalid=1 and wr_ostd=3.
  - Required: o_awvalid=0 and wr_ostd=0 immediately; i_awready=1 after release.
- **ID forcing.**
  - Stimulus: MST_ID_MASK='h10; AW with ID='h05, then AR with ID='h1F.
  - Required: o_awch ID='h15 and o_arch ID='h1F one cycle later; upper payload bits bit-exact.
- **Write limit.**
  - Stimulus: MST_OSTDREQ_NUM=4; 5 back-to-back AWs with o_awready=1 and no B.
  - Required: 4 accepted; wr_ostd=4; i_awready=0 holds the 5th.
  - Then: one B handshake; the 5th is accepted next cycle and wr_ostd returns to 4.
- **Simultaneous events.**
  - Stimulus: AW handshake and B handshake in the same cycle at wr_ostd=2.
  - Required: wr_ostd stays 2.
  - Stimulus: B with wr_ostd=0.
  - Required: wr_ostd stays 0.
- **Read bursts.**
  - Stimulus: 2 ARs, then an 8-beat R burst with rlast on beat 8, with i_rready toggling 1/0.
  - Required: rd_ostd stays 2 through beats 1-7, drops to 1 only after the beat-8 handshake; data and rlast pass unmodified.
- **W backpressure.**
  - Stimulus: stream 16 W beats with o_wready pattern 1,0,0,1,...
  - Required: o_wch and o_wlast hold during stalls; beats arrive in order with no loss or duplication; full rate when o_wready=1.
